expmu_sweep_scheduler: RTL and testbench
========================================

Name: expmu_sweep_scheduler

Overview:
- Shares one S0*exp(t*mu) pipeline between N_ASSETS requesters.
- Each granted requester gets one full sweep: t = T_MIN..T_MAX, one t per cycle, with its mu and S0 latched for the whole sweep.
- The pipeline output is tagged with (asset, t) and written into a shared result RAM at {asset, t-T_MIN}.
- Sits between the per-asset parameter sources and the exp-mu datapath/result memory in the risk-calculation top level.

Parameters:
- N_ASSETS, 4, number of requesters
- LOG_N, 2, clog2(N_ASSETS)
- T_MIN, 343, first time index of a sweep
- T_MAX, 511, last time index of a sweep
- LOGT, 9, width of the time index
- PIPE_LAT, 8, fixed pipeline latency from oPipeValid/oPipeT issue to the matching iPipeData

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- iReq  in  N_ASSETS  per-asset sweep request, level
- iMu  in  18*N_ASSETS  per-asset mu, 18 fraction bits; slice i = bits [18i+17:18i]
- iS  in  18*N_ASSETS  per-asset S0, 4 integer / 14 fraction bits
- oAck  out  N_ASSETS  one-cycle pulse: request accepted, mu/S latched
- oDone  out  N_ASSETS  one-cycle pulse: last result of that asset written
- oBusy  out  1  high in any state other than IDLE
- oPipeT  out  LOGT  time index to the pipeline
- oPipeMu  out  18  latched mu to the pipeline
- oPipeS  out  18  latched S0 to the pipeline
- oPipeValid  out  1  oPipeT is a live issue
- iPipeData  in  18  pipeline result, 3 integer / 15 fraction bits
- oWrEn  out  1  result RAM write strobe
- oWrAddr  out  LOG_N+LOGT  {asset_id, t-T_MIN}
- oWrData  out  18  equals iPipeData registered with the tag

Behaviour:
- Reset values:
  - All outputs 0; oPipeT = T_MIN.
  - State IDLE; round-robin pointer = 0; tag delay line cleared.
  - Reset mid-sweep aborts the sweep: no further oWrEn, no oDone. Partial RAM contents are undefined.
- States:
  - IDLE: if any iReq, grant the first set bit at or after the RR pointer, scanning upward with wrap. Latch that asset's iMu/iS and id. Next state SWEEP.
  - SWEEP: oPipeValid=1, oPipeT increments by 1 per cycle from T_MIN. In the cycle oPipeT==T_MAX, next state DRAIN.
  - DRAIN: counts PIPE_LAT cycles. Next state DONE.
  - DONE: oDone[id] pulses; RR pointer becomes id+1 mod N_ASSETS. Next state IDLE.
- Timing, request seen in IDLE at cycle A:
  - oAck[id] high in cycle A+1.
  - oPipeValid high in cycles A+1..A+L, L = T_MAX-T_MIN+1 (169).
  - oWrEn high in cycles A+1+PIPE_LAT..A+L+PIPE_LAT.
  - oDone in cycle A+L+PIPE_LAT+1.
  - Back in IDLE at A+L+PIPE_LAT+2; the next grant can be seen that cycle.
- Tag delay line: PIPE_LAT stages of {valid, id, t-T_MIN}. oWrEn/oWrAddr come from the last stage; oWrData = iPipeData sampled in the same cycle.
- Arithmetic: offset = oPipeT - T_MIN, unsigned LOGT bits; range 0..168. No wrap of t past T_MAX.
- Sweeps never overlap. The pipeline is fully drained before the next grant.
- iReq is sampled only in IDLE. Deassertion during SWEEP/DRAIN is ignored. A request still held after oDone is granted again in RR order.
- oPipeMu/oPipeS stay constant from the cycle after the grant until the next grant. iMu/iS changes during a sweep have no effect.
- Simultaneous requests are resolved by RR only; no asset is granted twice while another is pending.

Decomposition:
- Shared package:
  - state encoding (IDLE, SWEEP, DRAIN, DONE)
  - Q-format width constants: MU 18f, S 4i14f, OUT 3i15f
  - T_MIN, T_MAX, LOGT defaults
- One natural sub-module: expmu_rr_arbiter. Inputs: req vector and pointer. Outputs: grant one-hot and grant id, combinational.
- The tag delay line stays inline as a shift register.

Test Plan:
- Single request: iReq=0001 held, mu=0x00100, S0=1.0. Expect oAck[0] 1 cycle after, 169 consecutive oWrEn with oWrAddr 0..168, oDone[0] at A+178, then a second sweep since the request is still held.
- All four requesting from reset: grants in order 0,1,2,3,0. Each grant comes only after the previous oDone. oWrAddr upper bits equal the id.
- Requests 1010 with pointer at 2: asset 3 is granted first, then 1. No gap beyond the one DONE cycle.
- Pulse iReq[2] for one cycle while asset 0 sweeps: not granted if dropped before IDLE. Held: granted next.
- Change iMu[0] mid-sweep: oPipeMu is unchanged for the whole sweep.
- Assert RST at SWEEP offset 50: all outputs 0 immediately (asynchronous). No oWrEn or oDone afterwards. A fresh request after release restarts at offset 0.

Source files
------------

// File: rtl/expmu_sweep_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : expmu_sweep_scheduler_pkg
//  Purpose  : Shared state encoding, Q-format widths and default sweep
//             geometry for the exp-mu sweep scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package expmu_sweep_scheduler_pkg;

   // Default sweep geometry and requester count
   localparam int N_ASSETS_DEF = 4;
   localparam int LOG_N_DEF    = 2;
   localparam int T_MIN_DEF    = 343;
   localparam int T_MAX_DEF    = 511;
   localparam int LOGT_DEF     = 9;
   localparam int PIPE_LAT_DEF = 8;

   // mu: pure fraction, 18 fraction bits
   localparam int MU_FRAC  = 18;
   localparam int MU_W     = MU_FRAC;
   // S0: 4 integer / 14 fraction bits
   localparam int S_INT    = 4;
   localparam int S_FRAC   = 14;
   localparam int S_W      = S_INT + S_FRAC;
   // Pipeline result: 3 integer / 15 fraction bits
   localparam int OUT_INT  = 3;
   localparam int OUT_FRAC = 15;
   localparam int OUT_W    = OUT_INT + OUT_FRAC;

   // Scheduler states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_t;

   // Round-robin successor of a requester id, wrapping at n
   function automatic int next_rr(input int id, input int n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/expmu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : expmu_rr_arbiter
//  Purpose  : Combinational round-robin pick: first set request at or after
//             the pointer, scanning upward with wrap. One-hot and id out.
//  Revision : 1.0 - initial release
// ============================================================================
module expmu_rr_arbiter
   import expmu_sweep_scheduler_pkg::*;
#(
   parameter int N     = N_ASSETS_DEF,
   parameter int LOG_N = LOG_N_DEF
) (
   input  logic [N-1:0]     req,
   input  logic [LOG_N-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [LOG_N-1:0] grant_id
);

   logic [LOG_N:0]   idx;
   logic [LOG_N-1:0] sel;
   logic             found;

   // Scan N candidates starting at ptr; the first request hit wins
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      sel      = '0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr} + (LOG_N+1)'(i);
         if (idx >= (LOG_N+1)'(N)) begin
            idx = idx - (LOG_N+1)'(N);
         end
         sel = idx[LOG_N-1:0];
         if (!found && req[sel]) begin
            found      = 1'b1;
            grant[sel] = 1'b1;
            grant_id   = sel;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/expmu_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : expmu_sweep_scheduler
//  Purpose  : Time-shares one S0*exp(t*mu) pipeline between N_ASSETS
//             requesters. A granted asset gets a full t = T_MIN..T_MAX sweep;
//             results are tagged and written to {asset, t-T_MIN}.
//  Revision : 1.0 - initial release
// ============================================================================
module expmu_sweep_scheduler
   import expmu_sweep_scheduler_pkg::*;
#(
   parameter int N_ASSETS = N_ASSETS_DEF,
   parameter int LOG_N    = LOG_N_DEF,
   parameter int T_MIN    = T_MIN_DEF,
   parameter int T_MAX    = T_MAX_DEF,
   parameter int LOGT     = LOGT_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [N_ASSETS-1:0]       iReq,
   input  logic [MU_W*N_ASSETS-1:0]  iMu,
   input  logic [S_W*N_ASSETS-1:0]   iS,
   output logic [N_ASSETS-1:0]       oAck,
   output logic [N_ASSETS-1:0]       oDone,
   output logic                      oBusy,
   output logic [LOGT-1:0]           oPipeT,
   output logic [MU_W-1:0]           oPipeMu,
   output logic [S_W-1:0]            oPipeS,
   output logic                      oPipeValid,
   input  logic [OUT_W-1:0]          iPipeData,
   output logic                      oWrEn,
   output logic [LOG_N+LOGT-1:0]     oWrAddr,
   output logic [OUT_W-1:0]          oWrData
);

   localparam int              DRAIN_W   = $clog2(PIPE_LAT + 1);
   localparam logic [LOGT-1:0] T_FIRST   = LOGT'(T_MIN);
   localparam logic [LOGT-1:0] T_LAST    = LOGT'(T_MAX);
   localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(PIPE_LAT - 1);

   // One tag per in-flight pipeline issue
   typedef struct packed {
      logic             valid;
      logic [LOG_N-1:0] id;
      logic [LOGT-1:0]  off;
   } tag_t;

   sweep_state_t         state;
   sweep_state_t         state_nxt;
   logic [LOG_N-1:0]     rr_ptr;
   logic [LOG_N-1:0]     cur_id;
   logic [LOG_N-1:0]     grant_id;
   logic [N_ASSETS-1:0]  grant_oh;
   logic                 grant_any;
   logic [LOGT-1:0]      t_cur;
   logic [LOGT-1:0]      offset;
   logic [MU_W-1:0]      mu_lat;
   logic [S_W-1:0]       s_lat;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 sweeping;
   logic                 sweep_last;
   tag_t                 tag_line [PIPE_LAT];
   tag_t                 tag_last;

   expmu_rr_arbiter #(
      .N     (N_ASSETS),
      .LOG_N (LOG_N)
   ) u_arb (
      .req      (iReq),
      .ptr      (rr_ptr),
      .grant    (grant_oh),
      .grant_id (grant_id)
   );

   assign grant_any  = |grant_oh;
   assign sweeping   = (state == ST_SWEEP);
   assign sweep_last = sweeping && (t_cur == T_LAST);
   assign offset     = t_cur - T_FIRST;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; requests are only looked at in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_any) state_nxt = ST_SWEEP;
         ST_SWEEP: if (sweep_last) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_cnt == DRAIN_END) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State-derived outputs; ack marks the first issue of a sweep
   always_comb begin
      oAck       = '0;
      oDone      = '0;
      oBusy      = (state != ST_IDLE);
      oPipeValid = sweeping;
      if (sweeping && (t_cur == T_FIRST)) begin
         oAck[cur_id] = 1'b1;
      end
      if (state == ST_DONE) begin
         oDone[cur_id] = 1'b1;
      end
   end

   // Grant latch: id, mu and S0 held from grant until the next grant
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cur_id <= '0;
         mu_lat <= '0;
         s_lat  <= '0;
      end else if (state == ST_IDLE && grant_any) begin
         cur_id <= grant_id;
         mu_lat <= iMu[grant_id*MU_W +: MU_W];
         s_lat  <= iS[grant_id*S_W +: S_W];
      end
   end

   // Time index: restarts at T_MIN on grant, steps once per sweep cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         t_cur <= T_FIRST;
      end else if (state == ST_IDLE && grant_any) begin
         t_cur <= T_FIRST;
      end else if (sweeping) begin
         t_cur <= sweep_last ? T_FIRST : t_cur + LOGT'(1);
      end
   end

   // Drain counter covers the pipeline latency after the last issue
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         drain_cnt <= '0;
      end else if (state == ST_DRAIN) begin
         drain_cnt <= drain_cnt + DRAIN_W'(1);
      end else begin
         drain_cnt <= '0;
      end
   end

   // Round-robin pointer advances past the asset that just finished
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_ptr <= '0;
      end else if (state == ST_DONE) begin
         rr_ptr <= LOG_N'(next_rr(int'(cur_id), N_ASSETS));
      end
   end

   // Tag delay line matching the pipeline latency; idle slots carry zeros
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            tag_line[i] <= '0;
         end
      end else begin
         tag_line[0].valid <= sweeping;
         tag_line[0].id    <= sweeping ? cur_id : '0;
         tag_line[0].off   <= sweeping ? offset : '0;
         for (int i = 1; i < PIPE_LAT; i++) begin
            tag_line[i] <= tag_line[i-1];
         end
      end
   end

   assign tag_last   = tag_line[PIPE_LAT-1];
   assign oWrEn      = tag_last.valid;
   assign oWrAddr    = {tag_last.id, tag_last.off};
   assign oWrData    = tag_last.valid ? iPipeData : '0;
   assign oPipeT     = t_cur;
   assign oPipeMu    = mu_lat;
   assign oPipeS     = s_lat;

endmodule
`default_nettype wire

// File: tb/tb_expmu_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expmu_sweep_scheduler
//  Purpose  : Directed self-checking bench for expmu_sweep_scheduler with a
//             fixed-latency pipeline model driving iPipeData.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_expmu_sweep_scheduler;

   localparam int TMIN = 343;
   localparam int TMAX = 511;
   localparam int LAT  = 8;
   localparam int L    = TMAX - TMIN + 1;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  iReq;
   logic [71:0] iMu;
   logic [71:0] iS;
   logic [3:0]  oAck;
   logic [3:0]  oDone;
   logic        oBusy;
   logic [8:0]  oPipeT;
   logic [17:0] oPipeMu;
   logic [17:0] oPipeS;
   logic        oPipeValid;
   logic [17:0] iPipeData;
   logic        oWrEn;
   logic [10:0] oWrAddr;
   logic [17:0] oWrData;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [17:0] mu_tab [4];
   logic [17:0] s_tab  [4];
   logic [17:0] hist   [9];

   expmu_sweep_scheduler dut (
      .CLK        (CLK),
      .RST        (RST),
      .iReq       (iReq),
      .iMu        (iMu),
      .iS         (iS),
      .oAck       (oAck),
      .oDone      (oDone),
      .oBusy      (oBusy),
      .oPipeT     (oPipeT),
      .oPipeMu    (oPipeMu),
      .oPipeS     (oPipeS),
      .oPipeValid (oPipeValid),
      .iPipeData  (iPipeData),
      .oWrEn      (oWrEn),
      .oWrAddr    (oWrAddr),
      .oWrData    (oWrData)
   );

   always #5 CLK = ~CLK;

   // Pipeline model: result for issue t is t*37+5
   function automatic logic [17:0] pipe_f(input int t);
      return 18'(t * 37 + 5);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_params();
      for (int i = 0; i < 4; i++) begin
         iMu[i*18 +: 18] = mu_tab[i];
         iS[i*18 +: 18]  = s_tab[i];
      end
   endtask

   // One clock; afterwards the pipeline model has returned data issued LAT cycles ago
   task automatic step();
      logic [17:0] nv;
      @(posedge CLK);
      #1;
      nv = oPipeValid ? pipe_f(int'(oPipeT)) : 18'h0;
      for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
      hist[0]   = nv;
      iPipeData = hist[8];
      #1;
   endtask

   // Called in the IDLE cycle where asset id's grant is decided; returns in the next IDLE cycle
   task automatic run_sweep(input int id, input int ev1_rel, input logic [3:0] ev1_req,
                            input int ev2_rel, input logic [3:0] ev2_req, input int mu_rel);
      logic [17:0] emu, es;
      logic [1:0]  idb;
      logic [3:0]  ack_val, done_val;
      int ack_cnt, pv_cnt, pv_first, t_bad, mu_bad, wr_cnt, wr_first;
      int addr_bad, data_bad, done_cnt, done_rel;
      logic idle_busy;
      emu = mu_tab[id]; es = s_tab[id]; idb = 2'(id);
      ack_val = '0; done_val = '0; ack_cnt = 0; pv_cnt = 0; pv_first = -1;
      t_bad = 0; mu_bad = 0; wr_cnt = 0; wr_first = -1; addr_bad = 0;
      data_bad = 0; done_cnt = 0; done_rel = -1; idle_busy = 1'b1;
      for (int r = 1; r <= L + LAT + 2; r++) begin
         step();
         if (oAck != 4'b0) begin
            ack_cnt++;
            if (r == 1) ack_val = oAck;
         end
         if (oPipeMu !== emu || oPipeS !== es) mu_bad++;
         if (oPipeValid) begin
            if (pv_first < 0) pv_first = r;
            if (oPipeT !== 9'(TMIN + pv_cnt)) t_bad++;
            pv_cnt++;
         end
         if (oWrEn) begin
            if (wr_first < 0) wr_first = r;
            if (oWrAddr !== {idb, 9'(wr_cnt)}) addr_bad++;
            if (oWrData !== pipe_f(TMIN + wr_cnt)) data_bad++;
            wr_cnt++;
         end
         if (oDone != 4'b0) begin
            done_cnt++; done_rel = r; done_val = oDone;
         end
         if (r == L + LAT + 2) idle_busy = oBusy;
         if (r == ev1_rel) iReq = ev1_req;
         if (r == ev2_rel) iReq = ev2_req;
         if (r == mu_rel) begin
            mu_tab[0] = 18'h15555;
            drive_params();
         end
      end
      check($sformatf("a%0d_ack_value", id), ack_val, 32'(4'b1 << id));
      check($sformatf("a%0d_ack_count", id), ack_cnt, 1);
      check($sformatf("a%0d_valid_first", id), pv_first, 1);
      check($sformatf("a%0d_valid_count", id), pv_cnt, L);
      check($sformatf("a%0d_t_seq_errs", id), t_bad, 0);
      check($sformatf("a%0d_mu_s_changes", id), mu_bad, 0);
      check($sformatf("a%0d_wr_first", id), wr_first, 1 + LAT);
      check($sformatf("a%0d_wr_count", id), wr_cnt, L);
      check($sformatf("a%0d_wr_addr_errs", id), addr_bad, 0);
      check($sformatf("a%0d_wr_data_errs", id), data_bad, 0);
      check($sformatf("a%0d_done_cycle", id), done_rel, L + LAT + 1);
      check($sformatf("a%0d_done_count", id), done_cnt, 1);
      check($sformatf("a%0d_done_value", id), done_val, 32'(4'b1 << id));
      check($sformatf("a%0d_idle_after", id), idle_busy, 0);
   endtask

   // A few cycles with no request must stay idle
   task automatic idle_check(input string tag);
      int act;
      act = 0;
      for (int r = 0; r < 5; r++) begin
         step();
         if (oBusy || oAck != 4'b0 || oPipeValid) act++;
      end
      check(tag, act, 0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   initial begin
      int cnt;
      RST = 1'b1; iReq = '0; iMu = '0; iS = '0; iPipeData = '0;
      for (int k = 0; k < 9; k++) hist[k] = '0;
      mu_tab = '{18'h00100, 18'h01234, 18'h2ABCD, 18'h3FFFF};
      s_tab  = '{18'h04000, 18'h08000, 18'h0C000, 18'h02000};
      step();
      step();
      check("rst_ack", oAck, 0);
      check("rst_done", oDone, 0);
      check("rst_busy", oBusy, 0);
      check("rst_pipe_t", oPipeT, TMIN);
      check("rst_pipe_mu", oPipeMu, 0);
      check("rst_pipe_s", oPipeS, 0);
      check("rst_pipe_valid", oPipeValid, 0);
      check("rst_wr_en", oWrEn, 0);
      check("rst_wr_addr", oWrAddr, 0);
      check("rst_wr_data", oWrData, 0);
      RST = 1'b0;

      // Single held request: two back-to-back sweeps of asset 0
      mu_tab[0] = 18'h00100; s_tab[0] = 18'h04000; drive_params();
      iReq = 4'b0001;
      run_sweep(0, 0, 4'b0, 0, 4'b0, 0);
      run_sweep(0, 100, 4'b0000, 0, 4'b0, 0);
      idle_check("single_idle_after");

      // All four requesting from reset: 0,1,2,3,0
      do_reset();
      mu_tab = '{18'h00100, 18'h01234, 18'h2ABCD, 18'h3FFFF};
      drive_params();
      iReq = 4'b1111;
      run_sweep(0, 0, 4'b0, 0, 4'b0, 0);
      run_sweep(1, 0, 4'b0, 0, 4'b0, 0);
      run_sweep(2, 0, 4'b0, 0, 4'b0, 0);
      run_sweep(3, 0, 4'b0, 0, 4'b0, 0);
      run_sweep(0, 100, 4'b0000, 0, 4'b0, 0);

      // Pointer now 1: grant 1, then 1010 with pointer 2 gives 3 then 1
      iReq = 4'b0010;
      run_sweep(1, 100, 4'b1010, 0, 4'b0, 0);
      run_sweep(3, 0, 4'b0, 0, 4'b0, 0);
      run_sweep(1, 100, 4'b0000, 0, 4'b0, 0);

      // One-cycle pulse on asset 2 during asset 0's sweep, plus a mu change
      iReq = 4'b0001;
      run_sweep(0, 20, 4'b0100, 21, 4'b0000, 60);
      idle_check("pulse_not_granted");
      // Held request from asset 2 is granted after asset 0 (new mu latched)
      iReq = 4'b0001;
      run_sweep(0, 20, 4'b0100, 0, 4'b0, 0);
      run_sweep(2, 100, 4'b0000, 0, 4'b0, 0);

      // Asynchronous reset at sweep offset 50
      iReq = 4'b0001;
      for (int r = 1; r <= 51; r++) step();
      check("pre_rst_pipe_t", oPipeT, TMIN + 50);
      check("pre_rst_wr_en", oWrEn, 1);
      #1 RST = 1'b1;
      #1;
      check("arst_busy", oBusy, 0);
      check("arst_pipe_valid", oPipeValid, 0);
      check("arst_pipe_t", oPipeT, TMIN);
      check("arst_pipe_mu", oPipeMu, 0);
      check("arst_wr_en", oWrEn, 0);
      check("arst_wr_addr", oWrAddr, 0);
      iReq = 4'b0000;
      step();
      step();
      RST = 1'b0;
      cnt = 0;
      for (int r = 0; r < 30; r++) begin
         step();
         if (oWrEn || oDone != 4'b0 || oBusy) cnt++;
      end
      check("post_rst_activity", cnt, 0);
      iReq = 4'b0010;
      run_sweep(1, 100, 4'b0000, 0, 4'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
